// File: rtl/branch_history_table.sv
// branch_history_table
//   Table of 2-bit saturating branch counters indexed by the low PC bits.
//   Fetch side: registered 1-cycle lookup returning the counter and its
//   direction bit. Execute side: 2-stage read-modify-write update pipeline.
//   Stage U1 captures the index, the outcome and the current counter.
//   Stage U2 writes the saturated next value back to the table.
//   Back-to-back updates to the same index forward the value being written.
//
//   Optional build macro: PREDICTOR_BYPASS_EN
//     defined   - a lookup that hits the U2 write index returns the new value
//     undefined - such a lookup returns the pre-write table contents
module branch_history_table #(
   parameter int         PC_WIDTH   = 32,
   parameter int         INDEX_BITS = 5,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                lookup_valid,
   input  logic [PC_WIDTH-1:0] lookup_pc,
   output logic                predict_valid,
   output logic                predict_taken,
   output logic [1:0]          predict_state,
   input  logic                update_valid,
   input  logic [PC_WIDTH-1:0] update_pc,
   input  logic                update_taken,
   output logic                update_busy
);

   localparam int DEPTH = 2 ** INDEX_BITS;

   // Two-bit counter step: +1 on taken, -1 on not-taken, clamped at 00/11.
   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != 2'b11) nxt = cnt + 2'd1;
      end else begin
         if (cnt != 2'b00) nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

   logic [1:0]            bht [DEPTH];

   logic [INDEX_BITS-1:0] lk_idx_p0;
   logic [INDEX_BITS-1:0] upd_idx_p0;
   logic [1:0]            upd_cur_p0;
   logic [1:0]            lk_val_p0;

   logic                  vld_p1;
   logic [INDEX_BITS-1:0] idx_p1;
   logic                  taken_p1;
   logic [1:0]            cnt_p1;
   logic [1:0]            wr_val_p1;

   // Tag-free indexing: upper PC bits alias onto the same entry.
   assign lk_idx_p0  = lookup_pc[INDEX_BITS-1:0];
   assign upd_idx_p0 = update_pc[INDEX_BITS-1:0];

   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS], update_pc[PC_WIDTH-1:INDEX_BITS]};

   // ---- U2: saturated next value for the entry held in U1 ----
   assign wr_val_p1   = sat_step(cnt_p1, taken_p1);
   assign update_busy = vld_p1;

   // U1 read: take the value U2 is writing when the indices collide, else the table.
   always_comb begin
      upd_cur_p0 = bht[upd_idx_p0];
      if (vld_p1 && (idx_p1 == upd_idx_p0)) upd_cur_p0 = wr_val_p1;
   end

   // Lookup read: optionally sees the value U2 is committing this cycle.
   always_comb begin
      lk_val_p0 = bht[lk_idx_p0];
`ifdef PREDICTOR_BYPASS_EN
      if (vld_p1 && (idx_p1 == lk_idx_p0)) lk_val_p0 = wr_val_p1;
`endif
   end

   // ---- p0 -> p1: U1 capture of index, outcome and current counter ----
   // Update valid flag; reset drops any in-flight update.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= update_valid;
   end

   // U1 datapath capture; only meaningful while vld_p1 is set.
   always_ff @(posedge clock) begin
      if (update_valid) begin
         idx_p1   <= upd_idx_p0;
         taken_p1 <= update_taken;
         cnt_p1   <= upd_cur_p0;
      end
   end

   // ---- p1 -> table: U2 write-back ----
   // Counter table: reset to the initial state, written by U2.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) bht[i] <= INIT_STATE;
      end else if (vld_p1) begin
         bht[idx_p1] <= wr_val_p1;
      end
   end

   // ---- p0 -> p1: registered prediction, zeroed when no lookup ----
   // Prediction outputs follow lookup_valid one cycle later.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         predict_valid <= 1'b0;
         predict_taken <= 1'b0;
         predict_state <= 2'b00;
      end else begin
         predict_valid <= lookup_valid;
         predict_taken <= lookup_valid ? lk_val_p0[1] : 1'b0;
         predict_state <= lookup_valid ? lk_val_p0 : 2'b00;
      end
   end

endmodule
